// File: rtl/nn_param_loader_pkg.sv
// Shared sizes, state encoding and limit record for the NN parameter loader.
package nn_param_loader_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CFG_W      = 32;
    localparam int unsigned LAYER_W    = 2;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned NUM_LAYERS = 3;

    localparam int unsigned DEF_L1_NEURONS = 30;
    localparam int unsigned DEF_L1_WEIGHTS = 784;
    localparam int unsigned DEF_L2_NEURONS = 30;
    localparam int unsigned DEF_L2_WEIGHTS = 30;
    localparam int unsigned DEF_L3_NEURONS = 10;
    localparam int unsigned DEF_L3_WEIGHTS = 30;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BIAS   = 2'd1,
        ST_WEIGHT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] neurons;
        logic [CNT_W-1:0] weights;
    } limits_t;

endpackage

// File: rtl/nn_param_loader_if.sv
// Parameter word stream (valid/ready) from the DMA into the loader.
interface nn_param_loader_if;
    import nn_param_loader_pkg::*;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/nn_param_loader.sv
// Walks layers 1..3 / neurons / weights and turns the parameter stream into
// per-word bias and weight config strobes for the Layer instances.
module nn_param_loader
    import nn_param_loader_pkg::*;
#(
    parameter int unsigned L1_NEURONS = DEF_L1_NEURONS,
    parameter int unsigned L1_WEIGHTS = DEF_L1_WEIGHTS,
    parameter int unsigned L2_NEURONS = DEF_L2_NEURONS,
    parameter int unsigned L2_WEIGHTS = DEF_L2_WEIGHTS,
    parameter int unsigned L3_NEURONS = DEF_L3_NEURONS,
    parameter int unsigned L3_WEIGHTS = DEF_L3_WEIGHTS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    nn_param_loader_if.slave  s,
    output logic [CFG_W-1:0]  layer_num,
    output logic [CFG_W-1:0]  neuron_num,
    output logic [DATA_W-1:0] weight_value,
    output logic              weight_valid,
    output logic [DATA_W-1:0] bias_value,
    output logic              bias_valid,
    output logic              busy,
    output logic              done
);

    // Neuron and weight counts for the layer being loaded.
    function automatic limits_t layer_limits(input logic [LAYER_W-1:0] layer);
        limits_t lim;
        case (layer)
            LAYER_W'(2): lim = '{neurons: CNT_W'(L2_NEURONS), weights: CNT_W'(L2_WEIGHTS)};
            LAYER_W'(3): lim = '{neurons: CNT_W'(L3_NEURONS), weights: CNT_W'(L3_WEIGHTS)};
            default:     lim = '{neurons: CNT_W'(L1_NEURONS), weights: CNT_W'(L1_WEIGHTS)};
        endcase
        return lim;
    endfunction

    state_t             state, state_n;
    logic [LAYER_W-1:0] layer_cnt, layer_n;
    logic [CNT_W-1:0]   neuron_cnt, neuron_n;
    logic [CNT_W-1:0]   weight_cnt, weight_n;
    limits_t            lim_c;
    logic               ready_c;
    logic               hs_c;

    // Abort and reset gate ready combinationally so no word is taken in that cycle.
    assign ready_c   = ((state == ST_BIAS) || (state == ST_WEIGHT)) && !abort && !rst;
    assign hs_c      = ready_c && s.s_valid;
    assign s.s_ready = ready_c;
    assign lim_c     = layer_limits(layer_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            layer_cnt  <= '0;
            neuron_cnt <= '0;
            weight_cnt <= '0;
        end else begin
            state      <= state_n;
            layer_cnt  <= layer_n;
            neuron_cnt <= neuron_n;
            weight_cnt <= weight_n;
        end
    end

    always_comb begin
        state_n  = state;
        layer_n  = layer_cnt;
        neuron_n = neuron_cnt;
        weight_n = weight_cnt;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_n  = ST_BIAS;
                    layer_n  = LAYER_W'(1);
                    neuron_n = '0;
                    weight_n = '0;
                end
            end
            ST_BIAS: begin
                if (hs_c) begin
                    state_n = ST_WEIGHT;
                end
            end
            ST_WEIGHT: begin
                if (hs_c) begin
                    if (weight_cnt == lim_c.weights - CNT_W'(1)) begin
                        weight_n = '0;
                        state_n  = ST_BIAS;
                        if (neuron_cnt == lim_c.neurons - CNT_W'(1)) begin
                            neuron_n = '0;
                            if (layer_cnt == LAYER_W'(NUM_LAYERS)) begin
                                state_n = ST_DONE;
                            end else begin
                                layer_n = layer_cnt + LAYER_W'(1);
                            end
                        end else begin
                            neuron_n = neuron_cnt + CNT_W'(1);
                        end
                    end else begin
                        weight_n = weight_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_n  = ST_IDLE;
                layer_n  = '0;
                neuron_n = '0;
                weight_n = '0;
            end
            default: state_n = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_n  = ST_IDLE;
            layer_n  = '0;
            neuron_n = '0;
            weight_n = '0;
        end
    end

    // Config bus: strobe one cycle after the handshake, address/data held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_num    <= '0;
            neuron_num   <= '0;
            weight_value <= '0;
            weight_valid <= 1'b0;
            bias_value   <= '0;
            bias_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            bias_valid   <= hs_c && (state == ST_BIAS);
            weight_valid <= hs_c && (state == ST_WEIGHT);
            done         <= (state == ST_DONE) && !abort;
            // busy spans the done pulse and drops the cycle after it
            busy         <= (state_n != ST_IDLE) || ((state == ST_DONE) && !abort);
            if (hs_c) begin
                layer_num  <= CFG_W'(layer_cnt);
                neuron_num <= CFG_W'(neuron_cnt);
                if (state == ST_BIAS) begin
                    bias_value <= s.s_data;
                end else begin
                    weight_value <= s.s_data;
                end
            end
        end
    end

endmodule
